// File: rtl/storelines_sync.sv
// storelines_sync: clocked DEPTH x WORD_WIDTH word store with a four-phase
// REQ/ACK CPU port, a hardware zero-fill sequencer and a background scan port.
//
// Optional feature macro: STORELINES_PARITY_EN (per-line even parity, PERR).
//
// Ports:
//   CLK, RESET_n      clock (rising edge), asynchronous active-low reset
//   REQ, WE, A, D     CPU request, write enable, address, write data
//   ACK, Q            handshake acknowledge, registered read data
//   CLEAR, BUSY       start zero-fill (level), clear in progress
//   SCAN_EN           enable background display scan
//   SCAN_A, SCAN_Q    scanned address / word
//   SCAN_VALID        one-cycle strobe when SCAN_A/SCAN_Q update
//   PERR              parity error on last CPU read (0 without the macro)
module storelines_sync #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] D,
    output logic                  ACK,
    output logic [WORD_WIDTH-1:0] Q,
    input  logic                  CLEAR,
    output logic                  BUSY,
    input  logic                  SCAN_EN,
    output logic [ADDR_WIDTH-1:0] SCAN_A,
    output logic [WORD_WIDTH-1:0] SCAN_Q,
    output logic                  SCAN_VALID,
    output logic                  PERR
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DONE     = 2'd1,
        S_CLEARING = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [WORD_WIDTH-1:0]   mem [DEPTH];

    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [WORD_WIDTH-1:0]   w_wr_data;
    logic                    w_rd_en;
    logic                    w_scan;

    // Next state and per-cycle strobes; priority in IDLE is CLEAR > REQ > scan
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_addr   = A;
        w_wr_data   = D;
        w_rd_en     = 1'b0;
        w_scan      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CLEAR) begin
                    w_state_nxt = S_CLEARING;
                end else if (REQ) begin
                    w_state_nxt = S_DONE;
                    w_wr_en     = WE;
                    w_rd_en     = ~WE;
                end else if (SCAN_EN) begin
                    w_scan = 1'b1;
                end
            end
            S_DONE: begin
                if (!REQ) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEARING: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = '0;
                if (r_cnt == '1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            ACK        <= 1'b0;
            BUSY       <= 1'b0;
            Q          <= '0;
            SCAN_A     <= '0;
            SCAN_Q     <= '0;
            SCAN_VALID <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            ACK        <= (w_state_nxt == S_DONE);
            BUSY       <= (w_state_nxt == S_CLEARING);
            SCAN_VALID <= w_scan;
            // Counter wraps to 0 after the last line, ready for the next clear
            if (r_state == S_CLEARING) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
            if (w_rd_en) begin
                Q <= mem[A];
            end
            if (w_scan) begin
                SCAN_Q <= mem[r_ptr];
                SCAN_A <= r_ptr;
                r_ptr  <= r_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Store array is not reset; writes are blocked while reset is asserted
    always_ff @(posedge CLK) begin
        if (w_wr_en && RESET_n) begin
            mem[w_wr_addr] <= w_wr_data;
        end
    end

`ifdef STORELINES_PARITY_EN
    logic par [DEPTH];

    // Even parity of the written word; the clear writes zero, giving parity 0
    always_ff @(posedge CLK) begin
        if (w_wr_en && RESET_n) begin
            par[w_wr_addr] <= ^w_wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            PERR <= 1'b0;
        end else if (w_rd_en) begin
            PERR <= (^mem[A]) ^ par[A];
        end
    end
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_storelines_sync.sv
module tb_storelines_sync;

    logic        CLK;
    logic        RESET_n;
    logic        REQ;
    logic        WE;
    logic [4:0]  A;
    logic [31:0] D;
    logic        ACK;
    logic [31:0] Q;
    logic        CLEAR;
    logic        BUSY;
    logic        SCAN_EN;
    logic [4:0]  SCAN_A;
    logic [31:0] SCAN_Q;
    logic        SCAN_VALID;
    logic        PERR;

    storelines_sync #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) uut (
        .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .WE(WE), .A(A), .D(D),
        .ACK(ACK), .Q(Q), .CLEAR(CLEAR), .BUSY(BUSY), .SCAN_EN(SCAN_EN),
        .SCAN_A(SCAN_A), .SCAN_Q(SCAN_Q), .SCAN_VALID(SCAN_VALID), .PERR(PERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total;
    int bad;
    logic [31:0] model [32];
    logic [31:0] exp_q_fifo [$];
    logic        exp_p_fifo [$];

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp_q;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [4:0] b;
        b = 5'(i);
        return {b, b, b, b, b, b, 2'b00};
    endfunction

    // One four-phase access; for reads the expected Q/PERR go to the scoreboard on drive
    task automatic access(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] eq, input logic ep);
        logic [31:0] qx;
        logic        px;
        @(negedge CLK);
        REQ = 1'b1; WE = we; A = a; D = d;
        if (!we) begin
            exp_q_fifo.push_back(eq);
            exp_p_fifo.push_back(ep);
        end else begin
            model[a] = d;
        end
        @(negedge CLK);
        chk("ack_rise", 32'(ACK), 32'd1);
        if (!we && exp_q_fifo.size() > 0) begin
            qx = exp_q_fifo.pop_front();
            px = exp_p_fifo.pop_front();
            chk("read_q", Q, qx);
            chk("read_perr", 32'(PERR), 32'(px));
        end
        REQ = 1'b0;
        @(negedge CLK);
        chk("ack_fall", 32'(ACK), 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 5'(i), 32'd0, model[i], 1'b0);
        end
        $display("%s reads done", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic ack_seen;
        logic ack_busy;

        total = 0; bad = 0;
        RESET_n = 1'b0; REQ = 1'b0; WE = 1'b0; A = '0; D = '0;
        CLEAR = 1'b0; SCAN_EN = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'hx;

        vecs[0] = '{1'b1, 5'h00, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'h00, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'h1F, 32'h0F0F0F0F, 32'h0};
        vecs[3] = '{1'b1, 5'h00, 32'hF0F0F0F0, 32'h0};
        vecs[4] = '{1'b0, 5'h1F, 32'h0,        32'h0F0F0F0F};
        vecs[5] = '{1'b0, 5'h00, 32'h0,        32'hF0F0F0F0};

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_q", Q, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_scan_a", 32'(SCAN_A), 32'd0);
        chk("rst_scan_q", SCAN_Q, 32'd0);
        chk("rst_scan_valid", 32'(SCAN_VALID), 32'd0);
        chk("rst_perr", 32'(PERR), 32'd0);
        RESET_n = 1'b1;

        // Table-driven handshakes
        for (int i = 0; i < 6; i++) begin
            access(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp_q, 1'b0);
        end

        // Fill pattern and scan 40 slots with wrap
        for (int i = 0; i < 32; i++) access(1'b1, 5'(i), pat(i), 32'd0, 1'b0);
        @(negedge CLK);
        SCAN_EN = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            chk("scan_valid", 32'(SCAN_VALID), 32'd1);
            chk("scan_a", 32'(SCAN_A), 32'(k % 32));
            chk("scan_q", SCAN_Q, pat(k % 32));
        end
        SCAN_EN = 1'b0;
        @(negedge CLK);
        chk("scan_idle_valid", 32'(SCAN_VALID), 32'd0);
        chk("scan_hold_a", 32'(SCAN_A), 32'd7);
        // A CPU read with the scan disabled leaves the pointer frozen at 8
        access(1'b0, 5'd2, 32'd0, pat(2), 1'b0);
        SCAN_EN = 1'b1;
        @(negedge CLK);
        SCAN_EN = 1'b0;
        chk("scan_resume_valid", 32'(SCAN_VALID), 32'd1);
        chk("scan_resume_a", 32'(SCAN_A), 32'd8);
        chk("scan_resume_q", SCAN_Q, pat(8));

        // CLEAR and a write REQ on the same edge: clear wins, write is pending
        @(negedge CLK);
        CLEAR = 1'b1; REQ = 1'b1; WE = 1'b1; A = 5'h05; D = 32'h12345678;
        busy_cnt = 0; ack_seen = 1'b0; ack_busy = 1'b0;
        for (int n = 0; n < 100 && !ack_seen; n++) begin
            @(negedge CLK);
            CLEAR = 1'b0;
            if (BUSY) busy_cnt++;
            if (ACK && BUSY) ack_busy = 1'b1;
            if (ACK) ack_seen = 1'b1;
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clear_pending_ack", 32'(ack_seen), 32'd1);
        chk("clear_ack_during_busy", 32'(ack_busy), 32'd0);
        REQ = 1'b0;
        @(negedge CLK);
        chk("clear_ack_fall", 32'(ACK), 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[5] = 32'h12345678;
        read_all("after_clear");

        // Reset during a clear, after lines 0..9 have been zeroed
        for (int i = 0; i < 32; i++) access(1'b1, 5'(i), ~pat(i), 32'd0, 1'b0);
        access(1'b0, 5'd31, 32'd0, ~pat(31), 1'b0);
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        chk("midclear_busy", 32'(BUSY), 32'd1);
        repeat (10) @(negedge CLK);
        RESET_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ACK), 32'd0);
        chk("midrst_q", Q, 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_scan_a", 32'(SCAN_A), 32'd0);
        chk("midrst_scan_q", SCAN_Q, 32'd0);
        chk("midrst_scan_valid", 32'(SCAN_VALID), 32'd0);
        chk("midrst_perr", 32'(PERR), 32'd0);
        @(negedge CLK);
        RESET_n = 1'b1;
        for (int i = 0; i < 10; i++) model[i] = 32'd0;
        read_all("after_midclear_reset");

`ifdef STORELINES_PARITY_EN
        access(1'b1, 5'd3, 32'hAAAAAAAA, 32'd0, 1'b0);
        @(negedge CLK);
        uut.mem[3][0] = ~uut.mem[3][0];
        access(1'b0, 5'd3, 32'd0, 32'hAAAAAAAB, 1'b1);
        access(1'b1, 5'd3, 32'hAAAAAAAA, 32'd0, 1'b0);
        access(1'b0, 5'd3, 32'd0, 32'hAAAAAAAA, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
